load_scoreboard: RTL

Per-register scoreboard on the producer side of the pipeline's data-hazard logic. It records destination registers of loads issued into the variable-latency data-memory path and stalls ID while any source operand is still waiting on one of them. Once a load completes, its value is picked up by the existing MEM/WB bypass network. Sits beside the ID/EX boundary and is fed by the EX, MEM-response and flush paths.

---
 rtl/pipeline_pkg.sv | 10 +
 rtl/sb_counter.sv | 54 +++++
 rtl/load_scoreboard.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants for the load scoreboard.
// Register-file geometry and default outstanding-load limits.
package pipeline_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int NUM_REGS        = 32;
  localparam int MAX_PER_REG_DEF = 3;
  localparam int MAX_TOTAL_DEF   = 4;

endpackage

// File: rtl/sb_counter.sv
// Guarded up/down counter: one increment, two decrements, limit.
// Ports: clk/rst, inc/blk/dec_a/dec_b in; q, ovf/unf, a_ok/b_ok out.
module sb_counter #(
  parameter int LIMIT = 3,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         blk,
  input  logic         dec_a,
  input  logic         dec_b,
  output logic [W-1:0] q,
  output logic         ovf,
  output logic         unf,
  output logic         a_ok,
  output logic         b_ok
);

  localparam int XW = W + 2;

  logic [XW-1:0] qx;
  logic [XW-1:0] avail;
  logic [XW-1:0] n;
  logic [XW-1:0] sub;
  logic [W-1:0]  q_next;
  logic          up;
  logic          apply;

  assign qx = XW'(q);

  // Net-result limit check: same-cycle decrements free a slot.
  assign ovf = inc
    && (qx + XW'(1) > XW'(LIMIT) + XW'(dec_a) + XW'(dec_b));

  // An increment that fits may satisfy a same-cycle decrement.
  assign up    = inc & ~ovf;
  assign apply = up & ~blk;
  assign avail = qx + XW'(up);

  assign a_ok = dec_a && (avail != '0);
  assign b_ok = dec_b && (avail > XW'(a_ok));
  assign unf  = (dec_a & ~a_ok) | (dec_b & ~b_ok);

  assign n      = qx + XW'(apply);
  assign sub    = XW'(a_ok) + XW'(b_ok);
  assign q_next = (n >= sub) ? W'(n - sub) : '0;

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_next;
  end

endmodule

// File: rtl/load_scoreboard.sv
// Outstanding-load scoreboard: per-rd counters and ID stall.
// Ports: issue/done/kill events, ID sources; stall, busy, full, flags.
module load_scoreboard
  import pipeline_pkg::*;
#(
  parameter int MAX_PER_REG = MAX_PER_REG_DEF,
  parameter int MAX_TOTAL   = MAX_TOTAL_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic                  i_done_valid,
  input  logic [REG_ADDR_W-1:0] i_done_rd,
  input  logic                  i_kill_valid,
  input  logic [REG_ADDR_W-1:0] i_kill_rd,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  output logic                  o_stall,
  output logic [NUM_REGS-1:0]   o_busy,
  output logic                  o_full,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int CW = $clog2(MAX_PER_REG + 1);
  localparam int TW = $clog2(MAX_TOTAL + 1);

  logic [NUM_REGS-1:0][CW-1:0] cnt;
  logic [NUM_REGS-1:0]         reg_ovf;
  logic [NUM_REGS-1:0]         reg_unf;
  logic [NUM_REGS-1:0]         d_ok;
  logic [NUM_REGS-1:0]         k_ok;
  logic [NUM_REGS-1:0]         busy;
  logic [NUM_REGS-1:0]         bypass;
  logic [NUM_REGS-1:0]         pend;
  logic [TW-1:0]               total;
  logic [1:0]                  tot_ok_unused;

  logic iss_hit;
  logic done_hit;
  logic kill_hit;
  logic tot_inc;
  logic tot_ovf;
  logic tot_unf;
  logic drop;
  logic ovf_q;
  logic unf_q;

  // x0 never holds a pending load.
  assign iss_hit  = i_issue_valid && (i_issue_rd != '0);
  assign done_hit = i_done_valid && (i_done_rd != '0);
  assign kill_hit = i_kill_valid && (i_kill_rd != '0);

  assign cnt[0]     = '0;
  assign reg_ovf[0] = 1'b0;
  assign reg_unf[0] = 1'b0;
  assign d_ok[0]    = 1'b0;
  assign k_ok[0]    = 1'b0;
  assign busy[0]    = 1'b0;
  assign bypass[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic sel_i;
    logic sel_d;
    logic sel_k;

    assign sel_i = iss_hit && (i_issue_rd == REG_ADDR_W'(r));
    assign sel_d = done_hit && (i_done_rd == REG_ADDR_W'(r));
    assign sel_k = kill_hit && (i_kill_rd == REG_ADDR_W'(r));

    sb_counter #(
      .LIMIT (MAX_PER_REG),
      .W     (CW)
    ) u_cnt (
      .clk   (i_clk),
      .rst   (i_rst),
      .inc   (sel_i),
      .blk   (drop),
      .dec_a (sel_d),
      .dec_b (sel_k),
      .q     (cnt[r]),
      .ovf   (reg_ovf[r]),
      .unf   (reg_unf[r]),
      .a_ok  (d_ok[r]),
      .b_ok  (k_ok[r])
    );

    assign busy[r] = cnt[r] != '0;

    // Last pending load returning now: WB bypass covers the read.
    assign bypass[r] = (cnt[r] == CW'(1))
      && (sel_d || sel_k) && !sel_i;
  end

  // Total only sees events its register counter accepted.
  assign tot_inc = iss_hit && !reg_ovf[i_issue_rd];

  sb_counter #(
    .LIMIT (MAX_TOTAL),
    .W     (TW)
  ) u_total (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (tot_inc),
    .blk   (1'b0),
    .dec_a (|d_ok),
    .dec_b (|k_ok),
    .q     (total),
    .ovf   (tot_ovf),
    .unf   (tot_unf),
    .a_ok  (tot_ok_unused[0]),
    .b_ok  (tot_ok_unused[1])
  );

  assign drop = iss_hit && (reg_ovf[i_issue_rd] || tot_ovf);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | drop;
      unf_q <= unf_q | (|reg_unf) | tot_unf;
    end
  end

  assign pend = busy & ~bypass;

  assign o_stall =
    (i_id_rs1_used && (i_id_rs1 != '0) && pend[i_id_rs1]) ||
    (i_id_rs2_used && (i_id_rs2 != '0) && pend[i_id_rs2]);

  assign o_busy      = busy;
  assign o_full      = total == TW'(MAX_TOTAL);
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule
